// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// - MD_WORD, MD_TAG_W, MD_MUL_LAT: default datapath width, tag width and multiplier depth.
// - MD_OP_*: 3-bit op encodings. Encoding 7 is reserved and executes as MUL_W.
// - md_state_e: FSM state encodings.
// - Decode helpers shared by the unit and anything that issues to it.
package ex_muldiv_unit_pkg;

  localparam int unsigned MD_WORD    = 32;
  localparam int unsigned MD_TAG_W   = 5;
  localparam int unsigned MD_MUL_LAT = 2;

  localparam logic [2:0] MD_OP_MUL_W   = 3'd0;
  localparam logic [2:0] MD_OP_MULH_W  = 3'd1;
  localparam logic [2:0] MD_OP_MULH_WU = 3'd2;
  localparam logic [2:0] MD_OP_DIV_W   = 3'd3;
  localparam logic [2:0] MD_OP_MOD_W   = 3'd4;
  localparam logic [2:0] MD_OP_DIV_WU  = 3'd5;
  localparam logic [2:0] MD_OP_MOD_WU  = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_OP_DIV_W) || (op == MD_OP_MOD_W) ||
           (op == MD_OP_DIV_WU) || (op == MD_OP_MOD_WU);
  endfunction

  function automatic logic md_is_mod(input logic [2:0] op);
    return (op == MD_OP_MOD_W) || (op == MD_OP_MOD_WU);
  endfunction

  function automatic logic md_is_signed_div(input logic [2:0] op);
    return (op == MD_OP_DIV_W) || (op == MD_OP_MOD_W);
  endfunction

  // Low-half result: MUL_W and the reserved encoding.
  function automatic logic md_is_mul_low(input logic [2:0] op);
    return (op == MD_OP_MUL_W) || (op == 3'd7);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative radix-2 restoring divider on unsigned operands, one quotient bit per cycle.
// Ports:
// - clk, rst       clock, synchronous active-high reset (also used to abort)
// - start          load dividend/divisor and begin WORD iterations
// - dividend       unsigned dividend, sampled on start
// - divisor        unsigned non-zero divisor, sampled on start
// - busy           high for the WORD iteration cycles after start
// - quotient       final quotient once busy falls
// - remainder      final remainder once busy falls
module muldiv_div_core #(
  parameter int unsigned WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WORD-1:0] dividend,
  input  logic [WORD-1:0] divisor,
  output logic            busy,
  output logic [WORD-1:0] quotient,
  output logic [WORD-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(WORD + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD - 1);

  logic [WORD-1:0]  dsr;
  logic [CNT_W-1:0] cnt;
  logic [WORD:0]    trial;

  // Shifted partial remainder minus divisor; the MSB is the borrow (restore when set).
  always_comb begin
    trial = {remainder, quotient[WORD-1]} - {1'b0, dsr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dsr       <= '0;
      cnt       <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      quotient  <= dividend;
      remainder <= '0;
      dsr       <= divisor;
      cnt       <= '0;
    end else if (busy) begin
      if (!trial[WORD]) begin
        remainder <= trial[WORD-1:0];
        quotient  <= {quotient[WORD-2:0], 1'b1};
      end else begin
        remainder <= {remainder[WORD-2:0], quotient[WORD-1]};
        quotient  <= {quotient[WORD-2:0], 1'b0};
      end
      cnt <= cnt + CNT_W'(1);
      if (cnt == LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit beside the EX ALU. One operation at a time; EX is
// stalled until the registered result is presented for exactly one cycle.
// Ports:
// - clk, rst                 clock, synchronous active-high reset
// - flush                    kills the in-flight operation
// - in_valid, op, src_a,     EX holds a mul/div instruction with forwarded operands
//   src_b, tag_in            and its destination register tag
// - stall                    hold IF..EX this cycle
// - out_valid                one-cycle result pulse (state DONE)
// - out_data, out_tag        registered result and tag, meaningful when out_valid
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned WORD    = MD_WORD,
  parameter int unsigned MUL_LAT = MD_MUL_LAT,
  parameter int unsigned TAG_W   = MD_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [2:0]       op,
  input  logic [WORD-1:0]  src_a,
  input  logic [WORD-1:0]  src_b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             stall,
  output logic             out_valid,
  output logic [WORD-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned CNT_W = $clog2(WORD + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WORD - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WORD-1:0]  a_q;
  logic [TAG_W-1:0] tag_q;
  logic             q_neg, r_neg, dz;

  logic                   accept, div_op, div_zero, a_neg, b_neg;
  logic [WORD-1:0]        a_mag, b_mag;
  logic [WORD:0]          mul_a, mul_b;
  logic signed [2*WORD-1:0] mul_ax, mul_bx, prod;
  logic [2*WORD-1:0]      mul_pipe [MUL_LAT];
  logic [2*WORD-1:0]      mul_top;
  logic [WORD-1:0]        mul_res, fix_res, quo, rem;
  logic                   div_busy;

  always_comb begin
    accept   = (state == StIdle) && in_valid && !flush;
    div_op   = md_is_div(op);
    div_zero = div_op && (src_b == '0);
    a_neg    = md_is_signed_div(op) && src_a[WORD-1];
    b_neg    = md_is_signed_div(op) && src_b[WORD-1];
    a_mag    = a_neg ? -src_a : src_a;
    b_mag    = b_neg ? -src_b : src_b;
    // (WORD+1)-bit operands: sign-extend except for MULH_WU, which zero-extends.
    mul_a    = {(op != MD_OP_MULH_WU) && src_a[WORD-1], src_a};
    mul_b    = {(op != MD_OP_MULH_WU) && src_b[WORD-1], src_b};
    mul_ax   = {{(WORD-1){mul_a[WORD]}}, mul_a};
    mul_bx   = {{(WORD-1){mul_b[WORD]}}, mul_b};
    prod     = mul_ax * mul_bx;
  end

  always_comb begin
    mul_top = mul_pipe[MUL_LAT-1];
    mul_res = md_is_mul_low(op_q) ? mul_top[WORD-1:0] : mul_top[2*WORD-1:WORD];
    if (dz) begin
      fix_res = md_is_mod(op_q) ? a_q : '1;
    end else if (md_is_mod(op_q)) begin
      fix_res = r_neg ? -rem : rem;
    end else begin
      fix_res = q_neg ? -quo : quo;
    end
  end

  assign stall     = accept || (state == StMul) || (state == StDiv) || (state == StFix);
  assign out_valid = (state == StDone);

  muldiv_div_core #(
    .WORD(WORD)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst || flush),
    .start    (accept && div_op && !div_zero),
    .dividend (a_mag),
    .divisor  (b_mag),
    .busy     (div_busy),
    .quotient (quo),
    .remainder(rem)
  );

  // Product enters the chain on the accept edge so the last stage is ready in the final MUL cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MUL_LAT; k++) begin
        mul_pipe[k] <= '0;
      end
    end else begin
      if (accept) begin
        mul_pipe[0] <= prod;
      end
      for (int k = 1; k < MUL_LAT; k++) begin
        mul_pipe[k] <= mul_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      tag_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz       <= 1'b0;
      out_data <= '0;
      out_tag  <= '0;
    end else if (flush) begin
      state <= StIdle;
      cnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            op_q  <= op;
            a_q   <= src_a;
            tag_q <= tag_in;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            dz    <= div_zero;
            cnt   <= '0;
            if (!div_op) begin
              state <= StMul;
            end else if (div_zero) begin
              state <= StFix;
            end else begin
              state <= StDiv;
            end
          end
        end
        StMul: begin
          if (cnt == MUL_LAST) begin
            out_data <= mul_res;
            out_tag  <= tag_q;
            cnt      <= '0;
            state    <= StDone;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StDiv: begin
          // The core finishes on the same cycle the counter reaches its last iteration.
          if (cnt == DIV_LAST || !div_busy) begin
            cnt   <= '0;
            state <= StFix;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StFix: begin
          out_data <= fix_res;
          out_tag  <= tag_q;
          state    <= StDone;
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table plus hand-written
// flush, back-to-back and reset sequences.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  tag_in = '0;
  logic        stall, out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(
    .WORD   (32),
    .MUL_LAT(2),
    .TAG_W  (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .tag_in   (tag_in),
    .stall    (stall),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, hold in_valid through DONE, check latency, stall, data and tag.
  task automatic run_op(input vec_t v, input string nm);
    bit got = 1'b0;
    bit stall_ok = 1'b1;
    int lat = -1;
    @(posedge clk); #1;
    in_valid = 1'b1; op = v.op; src_a = v.a; src_b = v.b; tag_in = v.tag;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        lat = c;
        if (stall) stall_ok = 1'b0;
        break;
      end
      if (!stall) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk({nm, "_done"}, 32'(got), 32'd1);
    chk({nm, "_lat"}, 32'(lat), 32'(v.lat));
    chk({nm, "_data"}, out_data, v.exp);
    chk({nm, "_tag"}, 32'(out_tag), 32'(v.tag));
    chk({nm, "_stall"}, 32'(stall_ok), 32'd1);
  endtask

  task automatic idle_after(input string nm);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(out_valid), 32'd0);
    chk({nm, "_idle_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nvalid;
    vec_t v;

    vecs[0]  = '{MD_OP_MUL_W,   32'h0000_1234, 32'h0000_5678, 5'd1,  32'h0626_0060, 3};
    vecs[1]  = '{MD_OP_MULH_W,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 3};
    vecs[2]  = '{MD_OP_MULH_WU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 3};
    vecs[3]  = '{MD_OP_DIV_W,   32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 34};
    vecs[4]  = '{MD_OP_MOD_W,   32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFF, 34};
    vecs[5]  = '{MD_OP_DIV_WU,  32'hFFFF_FFFF, 32'h10,        5'd6,  32'h0FFF_FFFF, 34};
    vecs[6]  = '{MD_OP_DIV_W,   32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 34};
    vecs[7]  = '{MD_OP_MOD_W,   32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 34};
    vecs[8]  = '{MD_OP_DIV_WU,  32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 2};
    vecs[9]  = '{MD_OP_MOD_W,   32'd5,         32'd0,         5'd10, 32'd5,         2};
    vecs[10] = '{3'd7,          32'd6,         32'd7,         5'd11, 32'd42,        3};
    vecs[11] = '{MD_OP_MOD_WU,  32'd100,       32'd7,         5'd12, 32'd2,         34};
    vecs[12] = '{MD_OP_DIV_W,   32'd7,         32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 34};
    vecs[13] = '{MD_OP_MOD_W,   32'd7,         32'hFFFF_FFFE, 5'd14, 32'd1,         34};

    // Reset state, checked while rst is still high so in_valid cannot be accepted.
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_stall_eq_in_valid", 32'(stall), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
      idle_after($sformatf("vec%0d", i));
    end

    // DIV flushed at t+10; MUL 3*4 accepted at t+11 must be the only result through t+40.
    nvalid = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = MD_OP_DIV_W; src_a = 32'd100; src_b = 32'd3; tag_in = 5'd9;
    for (int c = 0; c <= 40; c++) begin
      if (c == 10) begin
        flush = 1'b1;
        in_valid = 1'b0;
      end
      if (c == 11) begin
        flush = 1'b0;
        chk("flush_state_idle", 32'(dut.state), 32'(StIdle));
        in_valid = 1'b1; op = MD_OP_MUL_W; src_a = 32'd3; src_b = 32'd4; tag_in = 5'd21;
      end
      if (c == 15) in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        nvalid++;
        chk("flush_mul_cycle", 32'(c), 32'd14);
        chk("flush_mul_data", out_data, 32'd12);
        chk("flush_mul_tag", 32'(out_tag), 32'd21);
      end
      @(posedge clk); #1;
    end
    chk("flush_valid_count", 32'(nvalid), 32'd1);

    // Flush arriving in DONE does not suppress the older result.
    in_valid = 1'b1; op = MD_OP_MUL_W; src_a = 32'd2; src_b = 32'd5; tag_in = 5'd17;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_flush_valid", 32'(out_valid), 32'd1);
    chk("done_flush_data", out_data, 32'd10);
    chk("done_flush_tag", 32'(out_tag), 32'd17);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("done_flush_after", 32'(out_valid), 32'd0);

    // Back-to-back MUL then DIV with in_valid never dropped between them.
    v = '{MD_OP_MUL_W, 32'd9, 32'd9, 5'd25, 32'd81, 3};
    run_op(v, "b2b_mul");
    v = '{MD_OP_DIV_WU, 32'd1000, 32'd10, 5'd26, 32'd100, 34};
    run_op(v, "b2b_div");
    idle_after("b2b");

    // Reset in the middle of a MUL clears the result registers and kills the op.
    @(posedge clk); #1;
    in_valid = 1'b1; op = MD_OP_MUL_W; src_a = 32'd7; src_b = 32'd8; tag_in = 5'd4;
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_out_tag", 32'(out_tag), 32'd0);
    nvalid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("midrst_no_result", 32'(nvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
